fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of decode. Owns the program counter and drives a synchronous instruction BRAM with 1-cycle read latency and a read enable.
- Presents pc/inst to decode and consumes decode's npc, stall (hazard or wait_time) and stop.
- Squashes the one wrong-path instruction after a taken branch, jump or jr by substituting the do-nothing encoding 32'h00000001 (SPECIAL, func 1).

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction BRAM,
// and squashes the single wrong-path instruction after a redirect.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stall,
  input  logic [31:0]       npc,
  input  logic              stop,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] f_pc, f_pc_nx;
  logic [31:0] d_pc, d_pc_nx;
  logic        d_valid, d_valid_nx;
  logic        start_accept, accept, halt_req, redirect;
  logic [31:0] npc_word, issue_pc;
  logic        unused_bits;

  always_comb begin
    start_accept = start && (state != RUN);
    accept       = d_valid && !stall;
    npc_word     = {npc[31:2], 2'b00};
    halt_req     = accept && stop;
    redirect     = accept && !stop && (npc_word != d_pc + 32'd4);
    issue_pc     = start_accept ? RESET_PC : f_pc;

    state_nx   = state;
    f_pc_nx    = f_pc;
    d_pc_nx    = d_pc;
    d_valid_nx = d_valid;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nx   = RUN;
          d_pc_nx    = RESET_PC;
          d_valid_nx = 1'b1;
          f_pc_nx    = RESET_PC + 32'd4;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_nx   = HALT;
            d_valid_nx = 1'b0;
          end else if (redirect) begin
            // The sequential fetch issued this cycle is the wrong path; drop it.
            d_pc_nx    = f_pc;
            d_valid_nx = 1'b0;
            f_pc_nx    = npc_word;
          end else begin
            d_pc_nx    = f_pc;
            d_valid_nx = 1'b1;
            f_pc_nx    = f_pc + 32'd4;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      f_pc        <= RESET_PC;
      d_pc        <= RESET_PC;
      d_valid     <= 1'b0;
      fetch_count <= '0;
    end else begin
      state   <= state_nx;
      f_pc    <= f_pc_nx;
      d_pc    <= d_pc_nx;
      d_valid <= d_valid_nx;
      if (accept) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign imem_en     = ((state == RUN) && !stall && !halt_req) || start_accept;
  assign imem_addr   = issue_pc[ADDR_W+1:2];
  assign pc          = d_pc;
  assign inst_valid  = d_valid;
  assign inst        = d_valid ? imem_rdata : 32'h0000_0001;
  assign halted      = (state == HALT);
  assign unused_bits = ^{npc[1:0], issue_pc[1:0], issue_pc[31:ADDR_W+2]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic
// against a presentation-level model of what decode should observe each cycle.
module tb_fetch_unit;
  localparam int unsigned AW  = 8;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk, rstn, start, stall, stop;
  logic [31:0]   npc, imem_rdata, pc, inst, fetch_count;
  logic          imem_en, inst_valid, halted;
  logic [AW-1:0] imem_addr;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall), .npc(npc), .stop(stop),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int checks = 0;
  int failures = 0;

  // Model of decode's view: running?, halted?, valid inst at m_pc, or one bubble before m_target.
  logic        m_run, m_halt, m_valid, m_bubble;
  logic [31:0] m_pc, m_target, m_count;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + ((a >> 2) % (1 << AW));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_valid = 0; m_bubble = 0;
    m_pc = RPC; m_target = RPC; m_count = 0;
  endtask

  task automatic step(input logic st, input logic stl, input logic [31:0] n, input logic sp);
    logic        exp_en;
    logic [31:0] fa;
    logic [31:0] nw;
    start = st; stall = stl; npc = n; stop = sp;
    #1;
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    if (m_valid) chk("pc", pc, m_pc);
    chk("inst", inst, m_valid ? word_at(m_pc) : 32'h0000_0001);
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("fetch_count", fetch_count, m_count);
    exp_en = (!m_run && st) || (m_run && !stl && !(m_valid && sp));
    chk("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
    if (exp_en) begin
      fa = !m_run ? RPC : (m_bubble ? m_target : m_pc + 32'd4);
      chk("imem_addr", {24'b0, imem_addr}, {24'b0, fa[AW+1:2]});
    end
    @(posedge clk);
    nw = {n[31:2], 2'b00};
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_halt = 0; m_valid = 1; m_bubble = 0; m_pc = RPC;
      end
    end else if (!stl) begin
      if (m_valid) begin
        m_count = m_count + 32'd1;
        if (sp) begin
          m_run = 0; m_halt = 1; m_valid = 0;
        end else if (nw == m_pc + 32'd4) begin
          m_pc = m_pc + 32'd4;
        end else begin
          m_valid = 0; m_bubble = 1; m_target = nw;
        end
      end else if (m_bubble) begin
        m_bubble = 0; m_valid = 1; m_pc = m_target;
      end
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rstn = 1'b0; start = 1'b0; stall = 1'b0; stop = 1'b0;
    #1;
    model_reset();
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
    chk("rst_inst", inst, 32'h0000_0001);
    chk("rst_pc", pc, RPC);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
    rstn = 1'b0; start = 0; stall = 0; stop = 0; npc = 0;
    model_reset();
    @(negedge clk);
    step(0, 0, 0, 0);
    rstn = 1'b1;
    step(0, 0, 0, 0);

    // Sequential fetch with a stall (and a stale redirect under it) at pc=4.
    step(1, 0, 0, 0);
    step(0, 0, 32'h4, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h80, 0);
    step(0, 0, 32'h8, 0);
    // Taken branch at pc=8 to 0x40; bubble ignores its npc; npc low bits ignored.
    step(0, 0, 32'h40, 0);
    step(0, 0, 32'h10, 1);
    step(0, 0, 32'h47, 0);
    step(0, 0, 32'h20, 0);
    step(0, 0, 32'h0, 0);
    // Stop wins over a simultaneous redirect; HALT stays quiet until start.
    step(0, 0, 32'h80, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, m_pc + 32'd4, 0);
    async_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // PC wrap at 2^32 and start ignored while running.
    step(1, 0, 0, 0);
    step(0, 0, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);
    step(0, 0, 32'h0, 0);
    step(1, 0, 32'h4, 0);
    step(0, 0, 32'h8, 0);

    for (int i = 0; i < 3000; i++) begin
      logic        st, stl, sp;
      logic [31:0] n;
      st  = ($urandom % 20) == 0;
      stl = ($urandom % 4) == 0;
      sp  = ($urandom % 40) == 0;
      n   = (($urandom % 8) < 5) ? m_pc + 32'd4 : $urandom;
      if (i % 1000 == 999) async_reset();
      else step(st, stl, n, sp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
